// File: rtl/step_decoder.sv
// step_decoder: six-channel step/direction decoder with signed position counters,
// homing, sticky status flags and a request/ack read port. Optional PU glitch filter: PULSE_FILTER_EN.
module step_decoder #(
  parameter int FILT_LEN = 4,
  parameter int POS_W    = 16
) (
  input  logic             sysclk,
  input  logic             RSTn,
  input  logic [5:0]       PU,
  input  logic [5:0]       DR,
  input  logic [5:0]       MF,
  input  logic [5:0]       Stop,
  input  logic             RdReq,
  input  logic [2:0]       RdSel,
  output logic             RdAck,
  output logic             RdErr,
  output logic [POS_W-1:0] RdData,
  output logic [5:0]       HomeFlag,
  output logic [5:0]       OvFlag,
  output logic [5:0]       Stray
);

  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACK} rdState_t;

  logic [5:0]       puMeta, puSync, drMeta, drSync;
  logic [5:0]       mfMeta, mfSync, stopMeta, stopSync;
  logic [5:0]       puFilt, puPrev, stopPrev;
  logic [5:0]       stepEdge, homeEdge;
  logic [POS_W-1:0] pos [6];
  logic [POS_W-1:0] selPos, rdDataReg;
  logic             rdErrReg, capture;
  rdState_t         state, nextState;

  // PU idles high, so its synchronizer resets high to avoid a false step after reset.
  always_ff @(posedge sysclk) begin
    if (!RSTn) begin
      puMeta   <= '1;
      puSync   <= '1;
      drMeta   <= '0;
      drSync   <= '0;
      mfMeta   <= '0;
      mfSync   <= '0;
      stopMeta <= '0;
      stopSync <= '0;
    end else begin
      puMeta   <= PU;
      puSync   <= puMeta;
      drMeta   <= DR;
      drSync   <= drMeta;
      mfMeta   <= MF;
      mfSync   <= mfMeta;
      stopMeta <= Stop;
      stopSync <= stopMeta;
    end
  end

`ifdef PULSE_FILTER_EN
  logic [3:0] filtCnt [6];

  // Filtered level only follows the synchronized PU after FILT_LEN cycles of disagreement.
  always_ff @(posedge sysclk) begin
    if (!RSTn) begin
      puFilt <= '1;
      for (int ch = 0; ch < 6; ch++) filtCnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 6; ch++) begin
        if (puSync[ch] != puFilt[ch]) begin
          if (filtCnt[ch] == 4'(FILT_LEN - 1)) begin
            puFilt[ch]  <= puSync[ch];
            filtCnt[ch] <= '0;
          end else begin
            filtCnt[ch] <= filtCnt[ch] + 4'd1;
          end
        end else begin
          filtCnt[ch] <= '0;
        end
      end
    end
  end
`else
  assign puFilt = puSync;
`endif

  always_ff @(posedge sysclk) begin
    if (!RSTn) begin
      puPrev   <= '1;
      stopPrev <= '0;
    end else begin
      puPrev   <= puFilt;
      stopPrev <= stopSync;
    end
  end

  assign stepEdge = puPrev & ~puFilt;
  assign homeEdge = stopSync & ~stopPrev;

  // Homing takes priority over a coincident step on the same channel.
  always_ff @(posedge sysclk) begin
    if (!RSTn) begin
      for (int ch = 0; ch < 6; ch++) pos[ch] <= '0;
      HomeFlag <= '0;
      OvFlag   <= '0;
      Stray    <= '0;
    end else begin
      for (int ch = 0; ch < 6; ch++) begin
        if (homeEdge[ch]) begin
          pos[ch]      <= '0;
          HomeFlag[ch] <= 1'b1;
          OvFlag[ch]   <= 1'b0;
          Stray[ch]    <= 1'b0;
        end else if (stepEdge[ch]) begin
          if (!mfSync[ch]) begin
            Stray[ch] <= 1'b1;
          end else if (drSync[ch]) begin
            pos[ch] <= pos[ch] + POS_ONE;
            if (pos[ch] == POS_MAX) OvFlag[ch] <= 1'b1;
          end else begin
            pos[ch] <= pos[ch] - POS_ONE;
            if (pos[ch] == POS_MIN) OvFlag[ch] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    selPos = '0;
    for (int ch = 0; ch < 6; ch++) begin
      if (RdSel == 3'(ch)) selPos = pos[ch];
    end
  end

  always_ff @(posedge sysclk) begin
    if (!RSTn) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    capture   = 1'b0;
    RdAck     = 1'b0;
    RdErr     = 1'b0;
    case (state)
      IDLE: begin
        if (RdReq) begin
          nextState = ACK;
          capture   = 1'b1;
        end
      end
      ACK: begin
        nextState = IDLE;
        RdAck     = 1'b1;
        RdErr     = rdErrReg;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!RSTn) begin
      rdDataReg <= '0;
      rdErrReg  <= 1'b0;
    end else if (capture) begin
      rdDataReg <= selPos;
      rdErrReg  <= (RdSel > 3'd5);
    end
  end

  assign RdData = rdDataReg;

endmodule

// File: tb/tb_step_decoder.sv
// tb_step_decoder: directed and randomized stimulus for step_decoder, checked against
// a pulse-level position/flag model. Honours PULSE_FILTER_EN for latency expectations.
module tb_step_decoder;

  localparam int POS_W    = 16;
  localparam int FILT_LEN = 4;
  localparam int PMAX     = 32767;
`ifdef PULSE_FILTER_EN
  localparam int LAT      = 3 + FILT_LEN;
  localparam int FASTC    = FILT_LEN + 1;
  localparam int STOPDLY  = FILT_LEN;
`else
  localparam int LAT      = 3;
  localparam int FASTC    = 1;
  localparam int STOPDLY  = 0;
`endif

  logic             sysclk;
  logic             RSTn;
  logic [5:0]       PU, DR, MF, Stop;
  logic             RdReq;
  logic [2:0]       RdSel;
  logic             RdAck, RdErr;
  logic [POS_W-1:0] RdData;
  logic [5:0]       HomeFlag, OvFlag, Stray;

  int         checks = 0;
  int         errors = 0;
  int         modelPos [6];
  logic [5:0] modelHome, modelOv, modelStray;

  step_decoder #(.FILT_LEN(FILT_LEN), .POS_W(POS_W)) dut (
    .sysclk(sysclk), .RSTn(RSTn), .PU(PU), .DR(DR), .MF(MF), .Stop(Stop),
    .RdReq(RdReq), .RdSel(RdSel), .RdAck(RdAck), .RdErr(RdErr), .RdData(RdData),
    .HomeFlag(HomeFlag), .OvFlag(OvFlag), .Stray(Stray)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int ch = 0; ch < 6; ch++) modelPos[ch] = 0;
    modelHome  = '0;
    modelOv    = '0;
    modelStray = '0;
  endfunction

  function automatic void modelHomeCh(input int ch);
    modelPos[ch]   = 0;
    modelHome[ch]  = 1'b1;
    modelOv[ch]    = 1'b0;
    modelStray[ch] = 1'b0;
  endfunction

  // One completed pulse on a channel, judged with the MF/DR levels the bench is driving.
  function automatic void modelStep(input int ch);
    if (!MF[ch]) begin
      modelStray[ch] = 1'b1;
    end else begin
      modelPos[ch] += DR[ch] ? 1 : -1;
      if (modelPos[ch] > PMAX) begin
        modelPos[ch] -= 65536;
        modelOv[ch] = 1'b1;
      end else if (modelPos[ch] < -PMAX - 1) begin
        modelPos[ch] += 65536;
        modelOv[ch] = 1'b1;
      end
    end
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic applyStimulus(input logic [5:0] mask, input int lowC, input int highC);
    PU = PU & ~mask;
    waitCycles(lowC);
    PU = PU | mask;
    waitCycles(highC);
    for (int ch = 0; ch < 6; ch++) if (mask[ch]) modelStep(ch);
  endtask

  task automatic readCheck(input logic [2:0] sel, input string tag);
    logic [15:0] expData;
    logic        expErr;
    expErr  = (sel > 3'd5);
    expData = '0;
    if (!expErr) expData = 16'(modelPos[int'(sel)]);
    RdReq = 1'b1;
    RdSel = sel;
    @(posedge sysclk);
    #1;
    RdReq = 1'b0;
    checkOutput({tag, ".ack"},  32'(RdAck),  32'(1'b1));
    checkOutput({tag, ".data"}, 32'(RdData), 32'(expData));
    checkOutput({tag, ".err"},  32'(RdErr),  32'(expErr));
    @(posedge sysclk);
    #1;
    checkOutput({tag, ".ackDrop"}, 32'(RdAck), 32'(1'b0));
    @(negedge sysclk);
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, ".home"},  32'(HomeFlag), 32'(modelHome));
    checkOutput({tag, ".ov"},    32'(OvFlag),   32'(modelOv));
    checkOutput({tag, ".stray"}, 32'(Stray),    32'(modelStray));
  endtask

  // Capture channel 0 on the k-th edge after the first low sample of a fresh pulse.
  task automatic latencyProbe(input int k, input bit expectNew, input string tag);
    int oldPos;
    oldPos = modelPos[0];
    PU[0] = 1'b0;
    waitCycles(k - 1);
    RdReq = 1'b1;
    RdSel = 3'd0;
    @(posedge sysclk);
    #1;
    RdReq = 1'b0;
    checkOutput({tag, ".ack"},  32'(RdAck),  32'(1'b1));
    checkOutput({tag, ".data"}, 32'(RdData), 32'(16'(expectNew ? oldPos + 1 : oldPos)));
    @(negedge sysclk);
    waitCycles(10 - k);
    PU[0] = 1'b1;
    waitCycles(10);
    modelStep(0);
  endtask

  initial begin
    logic [3:0] ackPattern;
    int         ackCount;
    int         action;
    int         ch;

    PU = '1; DR = '0; MF = '0; Stop = '0;
    RdReq = 1'b0; RdSel = '0; RSTn = 1'b0;
    modelReset();
    repeat (3) @(posedge sysclk);
    #1;
    checkOutput("reset.ack",  32'(RdAck),  32'd0);
    checkOutput("reset.err",  32'(RdErr),  32'd0);
    checkOutput("reset.data", 32'(RdData), 32'd0);
    checkFlags("reset");
    @(negedge sysclk);
    RSTn = 1'b1;
    waitCycles(3);

    $display("[TB] channel 0 counts ten up-steps");
    MF = 6'b000001;
    DR = 6'b000001;
    waitCycles(2);
    for (int i = 0; i < 10; i++) applyStimulus(6'b000001, 8, 8);
    readCheck(3'd0, "up10");

    $display("[TB] channel 2 counts down");
    MF[2] = 1'b1;
    DR[2] = 1'b0;
    waitCycles(2);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000100, 8, 8);
    readCheck(3'd2, "down3");
    checkOutput("down3.stray", 32'(Stray), 32'(modelStray));

    $display("[TB] coincident home and step on channel 3");
    MF[3] = 1'b1;
    DR[3] = 1'b1;
    waitCycles(2);
    applyStimulus(6'b001000, 8, 8);
    applyStimulus(6'b001000, 8, 8);
    readCheck(3'd3, "pre.home3");
    PU[3] = 1'b0;
    waitCycles(STOPDLY);
    Stop[3] = 1'b1;
    waitCycles(8 - STOPDLY);
    PU[3] = 1'b1;
    waitCycles(8);
    modelHomeCh(3);
    readCheck(3'd3, "home3");
    checkFlags("home3");
    applyStimulus(6'b001000, 8, 8);
    readCheck(3'd3, "stopHeld3");
    Stop[3] = 1'b0;
    waitCycles(4);

    $display("[TB] stray step on disabled channel 4");
    applyStimulus(6'b010000, 8, 8);
    checkOutput("stray4.flag", 32'(Stray), 32'(modelStray));
    readCheck(3'd4, "stray4");

    $display("[TB] channel 1 ramps to the positive limit and wraps");
    MF[1] = 1'b1;
    DR[1] = 1'b1;
    waitCycles(2);
    for (int i = 0; i < PMAX; i++) begin
      PU[1] = 1'b0;
      waitCycles(FASTC);
      PU[1] = 1'b1;
      waitCycles(FASTC);
      modelStep(1);
    end
    waitCycles(LAT + 2);
    readCheck(3'd1, "atMax1");
    checkFlags("atMax1");
    applyStimulus(6'b000010, 8, 8);
    readCheck(3'd1, "wrap1");
    checkFlags("wrap1");
    Stop[1] = 1'b1;
    waitCycles(5);
    modelHomeCh(1);
    Stop[1] = 1'b0;
    waitCycles(5);
    readCheck(3'd1, "home1");
    checkFlags("home1");

    $display("[TB] out-of-range select and held request");
    readCheck(3'd7, "sel7");
    readCheck(3'd6, "sel6");
    ackPattern = '0;
    ackCount = 0;
    RdReq = 1'b1;
    RdSel = 3'd2;
    for (int i = 0; i < 4; i++) begin
      @(posedge sysclk);
      #1;
      ackPattern[i] = RdAck;
      if (RdAck) ackCount++;
    end
    RdReq = 1'b0;
    checkOutput("held.count",   32'(ackCount),   32'd2);
    checkOutput("held.pattern", 32'(ackPattern), 32'(4'b0101));
    @(negedge sysclk);
    waitCycles(2);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      action = int'($urandom_range(9, 0));
      if (action < 6) begin
        MF = 6'($urandom);
        DR = 6'($urandom);
        waitCycles(2);
        applyStimulus(6'($urandom_range(63, 1)), int'($urandom_range(9, 5)), int'($urandom_range(9, 5)));
      end else if (action < 8) begin
        ch = int'($urandom_range(5, 0));
        Stop[ch] = 1'b1;
        waitCycles(5);
        modelHomeCh(ch);
        Stop[ch] = 1'b0;
        waitCycles(5);
      end else begin
        readCheck(3'($urandom_range(7, 0)), "rnd.read");
      end
      if (it % 8 == 7) checkFlags("rnd");
    end
    for (int i = 0; i < 6; i++) readCheck(3'(i), "final");
    checkFlags("final");

    $display("[TB] reset coinciding with a read request");
    RdReq = 1'b1;
    RdSel = 3'd0;
    RSTn = 1'b0;
    @(posedge sysclk);
    #1;
    RdReq = 1'b0;
    checkOutput("abort.ack", 32'(RdAck), 32'd0);
    @(posedge sysclk);
    #1;
    checkOutput("abort.ack2", 32'(RdAck),  32'd0);
    checkOutput("abort.data", 32'(RdData), 32'd0);
    modelReset();
    checkFlags("abort");
    @(negedge sysclk);
    RSTn = 1'b1;
    MF = 6'b000001;
    DR = 6'b000001;
    waitCycles(3);
    readCheck(3'd0, "postReset0");
    readCheck(3'd5, "postReset5");

    $display("[TB] step latency");
    latencyProbe(LAT, 1'b0, "lat.before");
    latencyProbe(LAT + 1, 1'b1, "lat.after");

`ifdef PULSE_FILTER_EN
    $display("[TB] short glitch is filtered");
    PU[0] = 1'b0;
    waitCycles(2);
    PU[0] = 1'b1;
    waitCycles(12);
    readCheck(3'd0, "glitch");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_decoder.md
STEP_DECODER -- requirements
Module: step_decoder

Interface
REQ-001 FILT_LEN, 4, cycles a synchronized PU level must stay stable before it is accepted (range 1..15; used only with PULSE_FILTER_EN).
REQ-002 POS_W, 16, width of each signed position counter.
REQ-003 sysclk  input  1  system clock; all logic on its rising edge.
REQ-004 RSTn  input  1  reset; synchronous, active-low.
REQ-005 PU  input  6  per-motor step pulse; idle high; one step = one high-to-low transition.
REQ-006 DR  input  6  per-motor direction; 1 = count up, 0 = count down.
REQ-007 MF  input  6  per-motor enable; steps are counted only while high.
REQ-008 Stop  input  6  per-motor limit/home switch; active high.
REQ-009 RdReq  input  1  read request, level-sampled.
REQ-010 RdSel  input  3  motor index to read (0..5).
REQ-011 RdAck  output  1  one-cycle read-data-valid strobe.
REQ-012 RdErr  output  1  high together with RdAck when RdSel > 5.
REQ-013 RdData  output  POS_W  signed position snapshot, valid while RdAck is high.
REQ-014 HomeFlag  output  6  sticky, set per motor on a Stop rising edge.
REQ-015 OvFlag  output  6  sticky, set per motor on position wrap-around.
REQ-016 Stray  output  6  sticky, set per motor on a step edge while MF is low.

Function
REQ-017 PU, DR, MF and Stop shall each pass through a 2-flop synchronizer before any use.
REQ-018 Step edge: synchronized, filtered PU equals 0 while its previous registered value equals 1.
REQ-019 Step edge with MF=1: Pos[ch] increments by 1 if DR=1 and decrements by 1 if DR=0, with DR sampled in the same cycle as the edge.
REQ-020 Step edge with MF=0: Pos[ch] stays unchanged and Stray[ch] is set.
REQ-021 Latency without the filter: Pos[ch] holds the new value 3 clock edges after the first edge that samples PU low.
REQ-022 Wrap-around: Pos wraps in two's complement (+max+1 becomes -max-1, and the reverse); OvFlag[ch] is set in the same cycle as the wrap.
REQ-023 Homing: a rising edge on synchronized Stop[ch] clears Pos[ch] to 0, sets HomeFlag[ch] and clears OvFlag[ch] and Stray[ch].
REQ-024 A homing edge and a step edge in the same cycle: homing wins, and Pos[ch] becomes 0.
REQ-025 While Stop[ch] stays high, steps continue to be counted from 0.
REQ-026 The read FSM has two states, IDLE and ACK.
REQ-027 IDLE -> ACK when RdReq=1; RdSel is captured on that edge.
REQ-028 ACK -> IDLE always after one cycle; RdAck=1 only in ACK.
REQ-029 RdData is the value of Pos[RdSel] before any update in the capture cycle.
REQ-030 RdSel > 5: RdData=0 and RdErr=1 in ACK.
REQ-031 RdReq held high gives RdAck on alternate cycles (IDLE, ACK, IDLE, ACK, ...).
REQ-032 Channels are fully independent; simultaneous events on different motors are all processed in the same cycle.

Reset
REQ-033 With RSTn=0 at a clock edge: all Pos=0, HomeFlag, OvFlag, Stray, RdAck, RdErr and RdData are 0, and the FSM is in IDLE.
REQ-034 Synchronizer and edge registers reset to PU=1 and Stop=0, so no step or homing edge is detected on the first cycle after reset.
REQ-035 Reset asserted mid-read aborts the read; no RdAck is issued for that request.

Configuration
REQ-036 Macro PULSE_FILTER_EN, when defined: a per-channel counter requires the synchronized PU to differ from the filtered value for FILT_LEN consecutive cycles before the filtered value changes.
REQ-037 With PULSE_FILTER_EN defined, a glitch shorter than FILT_LEN cycles is ignored, and step latency becomes 3+FILT_LEN edges.
REQ-038 With PULSE_FILTER_EN undefined, the filtered PU is the synchronized PU, and the filter logic is absent.

Verification
REQ-039 Reset, then MF=6'b000001, DR[0]=1, 10 PU[0] low pulses, each 8 cycles low and 8 high; read RdSel=0 -> RdData=10, RdAck for 1 cycle, RdErr=0.
REQ-040 DR[2]=0 and MF[2]=1, 3 pulses from reset -> Pos[2]=-3 (16'hFFFD); Stray=0.
REQ-041 Pos[1]=32767 with DR[1]=1, one more pulse -> Pos[1]=-32768 and OvFlag[1]=1; Stop[1] rising edge -> Pos[1]=0, OvFlag[1]=0, HomeFlag[1]=1.
REQ-042 Stop[3] rising edge in the same cycle as a step edge on motor 3 -> Pos[3]=0; MF[4]=0 with 1 pulse on PU[4] -> Pos[4] unchanged and Stray[4]=1.
REQ-043 RdReq=1 with RdSel=7 -> RdAck=1, RdErr=1, RdData=0; RdReq held high for 4 cycles -> exactly 2 RdAck pulses.
REQ-044 With PULSE_FILTER_EN defined and FILT_LEN=4: a 2-cycle low glitch on PU[0] -> no count; a 6-cycle low pulse -> count of 1, 7 edges after the first low sample.
